// File: rtl/timersoc_pio_pkg.sv
// Shared constants for the timersoc parallel-I/O output peripherals:
// register word addresses and the pulse-length field width.
package timersoc_pio_pkg;

  localparam int PULSE_LEN_W = 16;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd1;
  localparam logic [2:0] ADDR_PULSE     = 3'd2;
  localparam logic [2:0] ADDR_BLINK     = 3'd3;
  localparam logic [2:0] ADDR_OUTSET    = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;

  // A zero length still produces a one-cycle pulse.
  function automatic logic [PULSE_LEN_W-1:0] len_or_one(input logic [PULSE_LEN_W-1:0] len);
    return (len == '0) ? PULSE_LEN_W'(1) : len;
  endfunction

endpackage

// File: rtl/timersoc_pulse_timer.sv
// One-shot pulse engine: a shared down-counter holds a set of mask bits
// active for max(len,1) cycles after the most recent non-empty trigger.
// Also intended for the buzzer output.
module timersoc_pulse_timer
  import timersoc_pio_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_trig,
  input  logic [WIDTH-1:0]       i_mask,
  input  logic [PULSE_LEN_W-1:0] i_len,
  output logic [WIDTH-1:0]       o_active
);

  logic [PULSE_LEN_W-1:0] r_cnt;
  logic [WIDTH-1:0]       r_active;
  logic                   w_fire;

  // An empty mask is not a trigger: the running count keeps going.
  assign w_fire = i_trig && (i_mask != '0);

  // Trigger ORs the mask in and reloads; otherwise count down and drop all bits on the last cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_active <= '0;
    end else if (w_fire) begin
      r_active <= r_active | i_mask;
      r_cnt    <= len_or_one(i_len);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == PULSE_LEN_W'(1)) r_active <= '0;
    end
  end

  assign o_active = r_active;

endmodule

// File: rtl/timersoc_leds_pio.sv
// Avalon-MM LED output port: DATA register with set/clear aliases, a
// hardware one-shot pulse engine and, when TIMERSOC_LEDS_BLINK_EN is
// defined, a per-bit blink mask driven by a free-running prescaler.
module timersoc_leds_pio
  import timersoc_pio_pkg::*;
#(
  parameter int                     WIDTH           = 8,
  parameter logic [WIDTH-1:0]       RESET_VALUE     = '0,
  parameter logic [PULSE_LEN_W-1:0] PULSE_LEN_RESET = 16'd1000,
  parameter int                     BLINK_DIV       = 25000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic                   w_wr;
  logic [WIDTH-1:0]       w_wd;
  logic [WIDTH-1:0]       w_pulse_active;
  logic [WIDTH-1:0]       w_blinkterm;
  logic [WIDTH-1:0]       w_blink_rd;
  logic [WIDTH-1:0]       r_data;
  logic [PULSE_LEN_W-1:0] r_pulse_len;
  logic [31:0]            r_readdata;
  logic [WIDTH-1:0]       r_out;
  logic                   w_unused;

  assign w_wr     = chipselect && !write_n;
  assign w_wd     = writedata[WIDTH-1:0];
  // Upper write-data bits are intentionally ignored.
  assign w_unused = ^writedata;

  // DATA register and its atomic set/clear aliases; PULSE_LEN register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data      <= RESET_VALUE;
      r_pulse_len <= PULSE_LEN_RESET;
    end else if (w_wr) begin
      case (address)
        ADDR_DATA:      r_data      <= w_wd;
        ADDR_OUTSET:    r_data      <= r_data | w_wd;
        ADDR_OUTCLEAR:  r_data      <= r_data & ~w_wd;
        ADDR_PULSE_LEN: r_pulse_len <= writedata[PULSE_LEN_W-1:0];
        default: ;
      endcase
    end
  end

  timersoc_pulse_timer #(.WIDTH(WIDTH)) u_pulse (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_trig   (w_wr && (address == ADDR_PULSE)),
    .i_mask   (w_wd),
    .i_len    (r_pulse_len),
    .o_active (w_pulse_active)
  );

`ifdef TIMERSOC_LEDS_BLINK_EN
  localparam int PRESC_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  logic [PRESC_W-1:0] r_presc;
  logic               r_phase;
  logic [WIDTH-1:0]   r_blink;

  // Free-running prescaler; the phase flips each wrap. Writing BLINK leaves it running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
      r_phase <= 1'b0;
      r_blink <= '0;
    end else begin
      if (r_presc == PRESC_W'(BLINK_DIV - 1)) begin
        r_presc <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
      if (w_wr && (address == ADDR_BLINK)) r_blink <= w_wd;
    end
  end

  assign w_blinkterm = r_blink & {WIDTH{r_phase}};
  assign w_blink_rd  = r_blink;
`else
  logic w_unused_div;
  assign w_unused_div = ^BLINK_DIV;
  assign w_blinkterm  = '0;
  assign w_blink_rd   = '0;
`endif

  // Read mux registered every cycle, independent of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else begin
      case (address)
        ADDR_DATA:      r_readdata <= 32'(r_data);
        ADDR_PULSE_LEN: r_readdata <= 32'(r_pulse_len);
        ADDR_PULSE:     r_readdata <= 32'(w_pulse_active);
        ADDR_BLINK:     r_readdata <= 32'(w_blink_rd);
        default:        r_readdata <= '0;
      endcase
    end
  end

  // Output pins: data with blink inversion, forced high by active pulse bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_out <= RESET_VALUE;
    else          r_out <= (r_data ^ w_blinkterm) | w_pulse_active;
  end

  assign readdata = r_readdata;
  assign out_port = r_out;

endmodule

// File: tb/tb_timersoc_leds_pio.sv
// Self-checking bench for timersoc_leds_pio: an edge-indexed reference model
// (pulse expiry as an absolute edge number, blink phase from edge count),
// a per-cycle compare process, directed literal checks and random traffic.
module tb_timersoc_leds_pio;
  localparam int         WIDTH = 8;
  localparam logic [7:0] RV    = 8'hA5;
  localparam int         DIV   = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  always #5 clk = ~clk;

  timersoc_leds_pio #(
    .WIDTH(WIDTH), .RESET_VALUE(RV), .PULSE_LEN_RESET(16'd1000), .BLINK_DIV(DIV)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_e: edges since reset. Pulse bits in m_pmask are live after edge x iff x < m_pexp.
  logic [7:0]  m_data = RV;
  logic [15:0] m_len = 16'd1000;
  logic [7:0]  m_pmask = 8'h0;
  logic [7:0]  m_blink = 8'h0;
  int          m_pexp = 0;
  int          m_e = 0;
  logic [31:0] exp_rd = 32'h0;
  logic [7:0]  exp_out = RV;
  logic [7:0]  t_pact, t_bt, t_wd;
  int          t_eo;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_data = RV; m_len = 16'd1000; m_pmask = 8'h0; m_blink = 8'h0;
      m_pexp = 0; m_e = 0; exp_rd = 32'h0; exp_out = RV;
    end else begin
      t_eo   = m_e;
      t_pact = (t_eo < m_pexp) ? m_pmask : 8'h0;
      t_bt   = 8'h0;
`ifdef TIMERSOC_LEDS_BLINK_EN
      if (((t_eo / DIV) % 2) == 1) t_bt = m_blink;
`endif
      case (address)
        3'd0: exp_rd = {24'h0, m_data};
        3'd1: exp_rd = {16'h0, m_len};
        3'd2: exp_rd = {24'h0, t_pact};
`ifdef TIMERSOC_LEDS_BLINK_EN
        3'd3: exp_rd = {24'h0, m_blink};
`endif
        default: exp_rd = 32'h0;
      endcase
      exp_out = (m_data ^ t_bt) | t_pact;
      m_e = t_eo + 1;
      t_wd = writedata[7:0];
      if (chipselect && !write_n) begin
        case (address)
          3'd0: m_data = t_wd;
          3'd1: m_len = writedata[15:0];
          3'd2: if (t_wd != 8'h0) begin
                  m_pmask = t_pact | t_wd;
                  m_pexp  = m_e + ((m_len == 16'd0) ? 1 : int'(m_len));
                end
`ifdef TIMERSOC_LEDS_BLINK_EN
          3'd3: m_blink = t_wd;
`endif
          3'd4: m_data = m_data | t_wd;
          3'd5: m_data = m_data & ~t_wd;
          default: ;
        endcase
      end
    end
  end

  // Per-cycle comparison of both registered outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_port", {24'h0, out_port}, {24'h0, exp_out});
      check("readdata", readdata, exp_rd);
    end
  end

  // ---------------- stimulus ----------------
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  logic b0 [0:15];

  initial begin
    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_out", {24'h0, out_port}, 32'h0000_00A5);
    check("rst_rd", readdata, 32'h0);
    address = 3'd1;
    reset_n = 1'b1;
    chk_en  = 1'b1;
    @(negedge clk);
    check("rd_len_reset", readdata, 32'h0000_03E8);

    // DATA / OUTSET / OUTCLEAR.
    wr(3'd0, 32'h0000_000F); @(negedge clk);
    check("data_wr", {24'h0, out_port}, 32'h0F);
    wr(3'd4, 32'hFFFF_FF30 & 32'h0000_0030); @(negedge clk);
    check("outset", {24'h0, out_port}, 32'h3F);
    wr(3'd5, 32'h0000_0003); @(negedge clk);
    check("outclear", {24'h0, out_port}, 32'h3C);
    address = 3'd0; @(negedge clk);
    check("rd_data", readdata, 32'h3C);

    // Three-cycle pulse on bit 0.
    wr(3'd1, 32'd3); wr(3'd0, 32'h0); wr(3'd2, 32'h01);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check("pulse3_bit0", {31'h0, out_port[0]}, (i <= 3) ? 32'h1 : 32'h0);
      check("pulse3_rd", readdata, (i <= 3) ? 32'h1 : 32'h0);
    end

    // Retrigger two cycles later extends both bits.
    wr(3'd1, 32'd4); wr(3'd2, 32'h01); @(negedge clk); wr(3'd2, 32'h80);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check("retrig", {24'h0, out_port}, (i <= 4) ? 32'h81 : 32'h0);
    end

    // Zero length gives a one-cycle pulse; an empty mask does nothing.
    wr(3'd1, 32'hABCD_0000); wr(3'd2, 32'h02);
    @(negedge clk); check("len0_on", {24'h0, out_port}, 32'h02);
    @(negedge clk); check("len0_off", {24'h0, out_port}, 32'h00);
    wr(3'd2, 32'h0000_FF00);
    @(negedge clk); check("mask0", {24'h0, out_port}, 32'h00);

    // Asynchronous reset mid-pulse (and mid-blink if present).
    wr(3'd3, 32'h01); wr(3'd1, 32'd100); wr(3'd2, 32'hFF);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check("async_rst_out", {24'h0, out_port}, 32'hA5);
    check("async_rst_rd", readdata, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_out", {24'h0, out_port}, 32'hA5);
    end

`ifdef TIMERSOC_LEDS_BLINK_EN
    wr(3'd0, 32'h0); wr(3'd3, 32'h01);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      b0[i] = out_port[0];
    end
    for (int i = 0; i < 12; i++)
      check("blink_period", {31'h0, b0[i+4]}, {31'h0, ~b0[i]});
`else
    wr(3'd3, 32'hFF); wr(3'd0, 32'h0);
    address = 3'd3;
    repeat (2) @(negedge clk);
    check("blink_rd_off", readdata, 32'h0);
    check("blink_bit0_off", {31'h0, out_port[0]}, 32'h0);
    for (int i = 0; i < 16; i++) b0[i] = 1'b0;
`endif

    // Random traffic, one async reset in the middle.
    for (int n = 0; n < 400; n++) begin
      address    = 3'($urandom_range(0, 7));
      chipselect = 1'($urandom_range(0, 3) != 0);
      write_n    = 1'($urandom_range(0, 2) == 0);
      writedata  = $urandom;
      if (address == 3'd1) writedata = {writedata[31:16], 13'h0, writedata[2:0]};
      if (address == 3'd2 && $urandom_range(0, 3) == 0) writedata[7:0] = 8'h0;
      if (n == 200) begin
        #3 reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    chipselect = 1'b0; write_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
